ifu_instr_queue: RTL
====================

IFU_INSTR_QUEUE -- requirements
Module: ifu_instr_queue

Interface
REQ-001 SHALL have parameters: XLEN, default `XLEN, PC width; DEPTH, default 4, group-entry count (power of two, >=2).
REQ-002 SHALL have ports, one per line:
- clk_i  in  1  sole clock, rising edge.
- srst_n_i  in  1  reset, synchronous, active-low.
- flush_i  in  1  pipeline flush, discards all queued content.
- ifu_instr_i  in  128  fetch group, word k = bits [32k+31:32k].
- ifu_grouppc_i  in  XLEN  PC of word 0.
- ifu_validword_i  in  4  bit k set = word k valid.
- ifu_errtype_i  in  6  fetch exception code, 0 = none.
- ifu_valid_i  in  1  group offered.
- ifu_ready_o  out  1  queue accepts group.
- dec_instr_o  out  32  single instruction to decode.
- dec_pc_o  out  XLEN  its PC.
- dec_errtype_o  out  6  its exception code.
- dec_valid_o  out  1  instruction offered.
- dec_ready_i  in  1  decode accepts.
REQ-003 Upstream side SHALL match the IFU master modport signal set exactly (instr, grouppc, validword, errtype, valid, ready).

Function
REQ-004 Group transfer SHALL occur when ifu_valid_i && ifu_ready_o at a rising edge; instruction transfer when dec_valid_o && dec_ready_i.
REQ-005 ifu_ready_o SHALL equal (count < DEPTH) && !flush_i, from registered count only; no same-cycle credit from a pop when full.
REQ-006 Accepted groups with validword==0 and errtype==0 SHALL be dropped, not stored.
REQ-007 Storage: circular buffer of DEPTH entries {instr, grouppc, validword, errtype}, write/read pointers wrap modulo DEPTH, count 0..DEPTH.
REQ-008 No bypass: a group accepted at edge N SHALL drive dec_valid_o no earlier than after edge N (one-cycle minimum latency).
REQ-009 Head group with errtype==0 SHALL emit its valid words in ascending k, skipping clear bits; dec_instr_o = word k, dec_pc_o = grouppc + 4*k (XLEN-bit wrap), dec_errtype_o = 0.
REQ-010 Head group with errtype!=0 SHALL emit exactly one instruction: dec_instr_o = 0, dec_pc_o = grouppc, dec_errtype_o = errtype, regardless of validword.
REQ-011 A per-head remaining-word mask SHALL track unsent words; on each transfer the emitted bit clears; when the mask becomes zero (or the error entry is sent) the head SHALL retire in the same edge and the next entry's mask load from its validword.
REQ-012 Max throughput SHALL be one instruction per cycle, with no bubble between consecutive groups.
REQ-013 dec_* outputs SHALL hold stable while dec_valid_o && !dec_ready_i.
REQ-014 Push and pop in the same cycle SHALL keep count unchanged; push when empty and pop of last word SHALL both be correct.
REQ-015 flush_i high at an edge SHALL empty the queue (pointers, count, mask = 0), ignore any concurrent push/pop, and dec_valid_o SHALL be 0 in the following cycle; flush_i has priority over all except reset.
REQ-016 dec_valid_o SHALL be 0 combinationally while flush_i is high.

Reset
REQ-017 When srst_n_i is low at a rising edge: pointers, count, mask = 0; ifu_ready_o = 0 during reset cycle, 1 after release; dec_valid_o = 0; dec_instr_o, dec_pc_o, dec_errtype_o = 0.
REQ-018 Reset mid-operation SHALL discard all stored groups and partially emitted words; no stale output after release.
REQ-019 Storage arrays need no reset; outputs SHALL be masked to 0 when dec_valid_o = 0.

Verification
REQ-020 Push group pc=0x1000, validword=4'b1011, instr words A,B,C,D, dec_ready_i=1 -> outputs (A,0x1000),(B,0x1004),(D,0x100C) on three consecutive cycles, then dec_valid_o=0.
REQ-021 Push errtype=6'h01 at pc=0x2000, validword=4'b1111 -> single output instr=0, pc=0x2000, errtype=0x01.
REQ-022 dec_ready_i=0, push 4 full groups -> ifu_ready_o=0 after 4th; one pop per cycle afterward -> ifu_ready_o stays 0 until a head group retires, then 1 next cycle.
REQ-023 Queue holding 3 groups, flush_i pulse with ifu_valid_i=1 -> next cycle dec_valid_o=0, count=0, concurrent group not stored.
REQ-024 Push validword=0, errtype=0 -> never emitted; pc=0xFFFF_FFFF_FFFF_FFFC, validword=4'b0011 -> second PC wraps to 0x0.
REQ-025 Assert srst_n_i=0 mid-group after 1 of 4 words emitted -> after release dec_valid_o=0 and queue empty.

Source files
------------

// File: rtl/ifu_instr_queue.sv
// Instruction queue between fetch and decode. It buffers whole fetch groups and
// hands decode one instruction per cycle.
`ifndef XLEN
`define XLEN 64
`endif

module ifu_instr_queue #(
    parameter int unsigned XLEN  = `XLEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              flush_i,
    input  logic [127:0]      ifu_instr_i,
    input  logic [XLEN-1:0]   ifu_grouppc_i,
    input  logic [3:0]        ifu_validword_i,
    input  logic [5:0]        ifu_errtype_i,
    input  logic              ifu_valid_i,
    output logic              ifu_ready_o,
    output logic [31:0]       dec_instr_o,
    output logic [XLEN-1:0]   dec_pc_o,
    output logic [5:0]        dec_errtype_o,
    output logic              dec_valid_o,
    input  logic              dec_ready_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [127:0]    instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [3:0]      vw_q    [DEPTH];
    logic [5:0]      err_q   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    mask_q, mask_d;

    logic            head_valid;
    logic            head_is_err;
    logic [127:0]    head_instr;
    logic [XLEN-1:0] head_pc;
    logic [5:0]      head_err;
    logic [PW-1:0]   rd_next;
    logic [1:0]      sel_k;
    logic [3:0]      sel_oh;
    logic [3:0]      mask_after;
    logic            push;
    logic            pop;
    logic            retire;

    assign head_valid  = (count_q != '0);
    assign head_instr  = instr_q[rd_ptr_q];
    assign head_pc     = pc_q[rd_ptr_q];
    assign head_err    = err_q[rd_ptr_q];
    assign head_is_err = (head_err != 6'd0);
    assign rd_next     = rd_ptr_q + PW'(1);

    // Credit comes only from the registered count, so a pop never frees a slot early.
    assign ifu_ready_o = srst_n_i && !flush_i && (count_q < DEPTH_C);
    assign dec_valid_o = head_valid && !flush_i;

    assign push = ifu_valid_i && ifu_ready_o
                  && ((ifu_validword_i != 4'd0) || (ifu_errtype_i != 6'd0));
    assign pop  = dec_valid_o && dec_ready_i;

    // Lowest remaining word of the head group is the next one sent.
    always_comb begin
        sel_k = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask_q[k]) begin
                sel_k = 2'(k);
            end
        end
        sel_oh = 4'b0001 << sel_k;
    end

    assign mask_after = mask_q & ~sel_oh;
    assign retire     = pop && (head_is_err || (mask_after == 4'd0));

    always_comb begin
        dec_instr_o   = 32'd0;
        dec_pc_o      = '0;
        dec_errtype_o = 6'd0;
        if (dec_valid_o) begin
            if (head_is_err) begin
                dec_pc_o      = head_pc;
                dec_errtype_o = head_err;
            end else begin
                dec_instr_o = head_instr[{sel_k, 5'b00000} +: 32];
                dec_pc_o    = head_pc + {{(XLEN-4){1'b0}}, sel_k, 2'b00};
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mask_d   = mask_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (retire) begin
            rd_ptr_d = rd_next;
        end
        case ({push, retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The next head's mask comes from storage, or straight from the input
        // when the queue is about to be empty and a group is arriving.
        if (retire) begin
            if (count_q > CW'(1)) begin
                mask_d = vw_q[rd_next];
            end else if (push) begin
                mask_d = ifu_validword_i;
            end else begin
                mask_d = 4'd0;
            end
        end else if (pop) begin
            mask_d = mask_after;
        end else if (!head_valid && push) begin
            mask_d = ifu_validword_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mask_q   <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mask_q   <= mask_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr_q] <= ifu_instr_i;
            pc_q[wr_ptr_q]    <= ifu_grouppc_i;
            vw_q[wr_ptr_q]    <= ifu_validword_i;
            err_q[wr_ptr_q]   <= ifu_errtype_i;
        end
    end

endmodule
